multicycle_control_fsm: RTL and testbench

//  Parametrised multicycle control unit for the RV32I datapath.

---
 rtl/multicycle_control_fsm_if.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake bundle between the multicycle control unit and the
// instruction/data memory port.
//   mem_req   : controller -> memory, request active (FETCH, MEM)
//   mem_we    : controller -> memory, write strobe (store in MEM)
//   ir_load   : controller -> datapath, load IR this cycle
//   mem_ready : memory -> controller, current request completes
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic ir_load;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output ir_load,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  ir_load,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for an RV32I datapath.
// Sequences IDLE/FETCH/DECODE/EXECUTE/MEM/WRITE_BACK/FAULT, decodes the
// opcode into ALU controls and datapath enables, bounds memory waits with a
// timeout, holds WRITE_BACK for WB_CYCLES cycles and counts retired
// instructions.
// Ports:
//   clk, reset (async, active-low)
//   mem_bus      : memory handshake (mem_req, mem_we, ir_load, mem_ready)
//   run          : keep executing; sampled in IDLE and at instruction end
//   clear_fault  : FAULT -> IDLE
//   opcode       : IR[6:0], valid from DECODE onward
//   branch_taken : ALU compare result, valid in EXECUTE
//   state        : current state code
//   aluop, alu_src_imm, reg_write, pc_write, pc_branch : datapath controls
//   fault        : FAULT state flag
//   retired      : retired-instruction count (wraps)
module multicycle_control_fsm #(
  parameter int STATE_W   = 4,
  parameter int WB_CYCLES = 1,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_fsm_if.master mem_bus,
  input  logic                   run,
  input  logic                   clear_fault,
  input  logic [6:0]             opcode,
  input  logic                   branch_taken,
  output logic [STATE_W-1:0]     state,
  output logic [1:0]             aluop,
  output logic                   alu_src_imm,
  output logic                   reg_write,
  output logic                   pc_write,
  output logic                   pc_branch,
  output logic                   fault,
  output logic [CNT_W-1:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_MEM        = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  // OP_NONE doubles as the reset value of the latch and the illegal marker.
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_R      = 3'd1,
    OP_I      = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_BRANCH = 3'd5,
    OP_JAL    = 3'd6
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_dec;
  logic [7:0]       wait_cnt;
  logic [7:0]       wb_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             mem_timeout;
  logic             wb_last;
  logic             complete;
  state_t           end_state;

  always_comb begin
    op_dec = OP_NONE;
    case (opcode)
      7'b0110011: op_dec = OP_R;
      7'b0010011: op_dec = OP_I;
      7'b0000011: op_dec = OP_LOAD;
      7'b0100011: op_dec = OP_STORE;
      7'b1100011: op_dec = OP_BRANCH;
      7'b1101111: op_dec = OP_JAL;
      default:    op_dec = OP_NONE;
    endcase
  end

  // The wait counter holds the number of unanswered cycles so far, so the
  // TIMEOUT-th unanswered cycle is the one that sees TIMEOUT-1; a ready on
  // that same cycle still takes priority in the next-state logic.
  assign mem_timeout = (wait_cnt == 8'(TIMEOUT - 1)) && !mem_bus.mem_ready;
  assign wb_last     = (wb_cnt == 8'(WB_CYCLES - 1));
  assign end_state   = run ? S_FETCH : S_IDLE;

  // An instruction ends in exactly one of three places depending on its class.
  assign complete = ((state_q == S_EXECUTE) && (op_q == OP_BRANCH)) ||
                    ((state_q == S_MEM) && (op_q == OP_STORE) && mem_bus.mem_ready) ||
                    ((state_q == S_WRITE_BACK) && wb_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Wait counter restarts whenever ready arrives or the controller is not
  // waiting on memory, so FETCH and MEM each start their own timeout window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_NONE;
      wait_cnt  <= 8'd0;
      wb_cnt    <= 8'd0;
      retired_q <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= op_dec;
      if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_bus.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
      if ((state_q == S_WRITE_BACK) && !wb_last) wb_cnt <= wb_cnt + 8'd1;
      else                                       wb_cnt <= 8'd0;
      if (complete) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_bus.mem_ready) state_d = S_DECODE;
        else if (mem_timeout)  state_d = S_FAULT;
      end
      S_DECODE: state_d = (op_dec == OP_NONE) ? S_FAULT : S_EXECUTE;
      S_EXECUTE: begin
        case (op_q)
          OP_R, OP_I, OP_JAL: state_d = S_WRITE_BACK;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH:          state_d = end_state;
          default:            state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (mem_bus.mem_ready) state_d = (op_q == OP_LOAD) ? S_WRITE_BACK : end_state;
        else if (mem_timeout)  state_d = S_FAULT;
      end
      S_WRITE_BACK: if (wb_last) state_d = end_state;
      S_FAULT:      if (clear_fault) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_bus.mem_req = 1'b0;
    mem_bus.mem_we  = 1'b0;
    mem_bus.ir_load = 1'b0;
    aluop           = 2'b00;
    alu_src_imm     = 1'b0;
    reg_write       = 1'b0;
    pc_write        = complete;
    pc_branch       = 1'b0;
    fault           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_bus.mem_req = 1'b1;
        mem_bus.ir_load = mem_bus.mem_ready;
      end
      S_EXECUTE: begin
        case (op_q)
          OP_R:      aluop = 2'b10;
          OP_I: begin
            aluop       = 2'b10;
            alu_src_imm = 1'b1;
          end
          OP_LOAD, OP_STORE: alu_src_imm = 1'b1;
          OP_BRANCH: begin
            aluop     = 2'b01;
            pc_branch = branch_taken;
          end
          OP_JAL:    pc_branch = 1'b1;
          default:   aluop = 2'b00;
        endcase
      end
      S_MEM: begin
        mem_bus.mem_req = 1'b1;
        mem_bus.mem_we  = (op_q == OP_STORE);
      end
      S_WRITE_BACK: begin
        reg_write = (wb_cnt == 8'd0);
        pc_branch = (op_q == OP_JAL);
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

  assign state   = STATE_W'(state_q);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Each instruction is described at transaction level (class, fetch delay,
// memory delay, branch outcome, run at completion); the bench expands it into
// the per-cycle outputs the control unit must show and a single compare
// process checks them on every falling edge.
module tb_multicycle_control_fsm;
  localparam int STATE_W   = 4;
  localparam int WB_CYCLES = 3;
  localparam int TIMEOUT   = 15;
  localparam int CNT_W     = 4;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4, K_JAL = 5, K_ILL = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic clear_fault = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0;
  logic [STATE_W-1:0] state;
  logic [1:0] aluop;
  logic alu_src_imm, reg_write, pc_write, pc_branch, fault;
  logic [CNT_W-1:0] retired;

  multicycle_control_fsm_if mem_bus();

  multicycle_control_fsm #(
    .STATE_W(STATE_W), .WB_CYCLES(WB_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .mem_bus(mem_bus), .run(run), .clear_fault(clear_fault),
    .opcode(opcode), .branch_taken(branch_taken), .state(state), .aluop(aluop),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic exp_valid = 1'b0;
  logic [17:0] exp_vec = '0;
  logic [CNT_W-1:0] exp_retired = '0;
  logic [17:0] act_vec;
  logic [6:0] legal_opc [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

  assign act_vec = {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.ir_load, aluop, alu_src_imm,
                    reg_write, pc_write, pc_branch, fault, retired};

  task automatic check_output();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("[TB] FAIL outputs t=%0t got state=%0d vec=%b want state=%0d vec=%b",
               $time, act_vec[17:14], act_vec, exp_vec[17:14], exp_vec);
    end
  endtask

  always @(negedge clk) if (exp_valid) check_output();

  task automatic check_val(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [6:0] v);
    for (int i = 0; i < 6; i++) if (legal_opc[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] illegal_opcode();
    logic [6:0] v;
    v = 7'($urandom);
    while (is_legal(v)) v = 7'($urandom);
    return v;
  endfunction

  function automatic logic [1:0] kind_aluop(input int k);
    if (k == K_R || k == K_I) return 2'b10;
    if (k == K_BRANCH) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic kind_imm(input int k);
    return (k == K_I || k == K_LOAD || k == K_STORE);
  endfunction

  task automatic apply_stimulus(input logic r, input logic cf, input logic [6:0] opc,
                                input logic tk, input logic rdy);
    run = r;
    clear_fault = cf;
    opcode = opc;
    branch_taken = tk;
    mem_bus.mem_ready = rdy;
  endtask

  // One clock cycle: drive inputs, publish the outputs that cycle must show.
  task automatic emit(input logic [3:0] st, input logic mreq, input logic mwe, input logic irl,
                      input logic [1:0] aop, input logic imm, input logic rw, input logic pcw,
                      input logic pcb, input logic flt, input logic r, input logic cf,
                      input logic [6:0] opc, input logic tk, input logic rdy);
    apply_stimulus(r, cf, opc, tk, rdy);
    exp_vec = {st, mreq, mwe, irl, aop, imm, rw, pcw, pcb, flt, exp_retired};
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // n cycles of IDLE with run low, then one with run high (next: FETCH).
  task automatic idle_seq(input int n);
    for (int i = 0; i < n; i++)
      emit(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1'b0, rb(), 7'($urandom), rb(), rb());
    emit(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1'b1, rb(), 7'($urandom), rb(), rb());
  endtask

  // n cycles of FAULT with clear low, then clear (next: IDLE).
  task automatic fault_seq(input int n);
    for (int i = 0; i < n; i++)
      emit(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, rb(), 1'b0, 7'($urandom), rb(), rb());
    emit(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, rb(), 1'b1, 7'($urandom), rb(), rb());
  endtask

  // Entire instruction starting in FETCH. fd/md are unanswered cycles before
  // ready; a delay of TIMEOUT or more means memory never answers in time.
  task automatic run_instr(input int kind, input int fd, input int md, input logic tk,
                           input logic run_end, output int ncyc, output logic faulted);
    logic [6:0] opc;
    logic st;
    ncyc = 0;
    faulted = 1'b0;
    if (fd >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        emit(4'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), 7'($urandom), rb(), 1'b0);
        ncyc++;
      end
      faulted = 1'b1;
      return;
    end
    for (int i = 0; i < fd; i++) begin
      emit(4'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), 7'($urandom), rb(), 1'b0);
      ncyc++;
    end
    emit(4'd1, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), 7'($urandom), rb(), 1'b1);
    ncyc++;
    opc = (kind == K_ILL) ? illegal_opcode() : legal_opc[kind];
    emit(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), opc, rb(), rb());
    ncyc++;
    if (kind == K_ILL) begin
      faulted = 1'b1;
      return;
    end
    if (kind == K_BRANCH) begin
      emit(4'd3, 0, 0, 0, kind_aluop(kind), kind_imm(kind), 0, 1, tk, 0, run_end, rb(), opc, tk, rb());
      ncyc++;
      exp_retired = exp_retired + 1'b1;
      return;
    end
    emit(4'd3, 0, 0, 0, kind_aluop(kind), kind_imm(kind), 0, 0, kind == K_JAL, 0,
         rb(), rb(), opc, rb(), rb());
    ncyc++;
    if (kind == K_LOAD || kind == K_STORE) begin
      st = (kind == K_STORE);
      if (md >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++) begin
          emit(4'd5, 1, st, 0, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), opc, rb(), 1'b0);
          ncyc++;
        end
        faulted = 1'b1;
        return;
      end
      for (int i = 0; i < md; i++) begin
        emit(4'd5, 1, st, 0, 2'b00, 0, 0, 0, 0, 0, rb(), rb(), opc, rb(), 1'b0);
        ncyc++;
      end
      emit(4'd5, 1, st, 0, 2'b00, 0, 0, st, 0, 0, st ? run_end : rb(), rb(), opc, rb(), 1'b1);
      ncyc++;
      if (st) begin
        exp_retired = exp_retired + 1'b1;
        return;
      end
    end
    for (int i = 0; i < WB_CYCLES; i++) begin
      emit(4'd4, 0, 0, 0, 2'b00, 0, i == 0, i == WB_CYCLES - 1, kind == K_JAL, 0,
           (i == WB_CYCLES - 1) ? run_end : rb(), rb(), opc, rb(), rb());
      ncyc++;
    end
    exp_retired = exp_retired + 1'b1;
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 0;
    if (r < 85) return $urandom_range(1, 4);
    if (r < 95) return $urandom_range(5, TIMEOUT - 1);
    return $urandom_range(TIMEOUT, TIMEOUT + 3);
  endfunction

  initial begin
    int n;
    logic f;
    logic in_fetch;
    int kind;
    logic re;

    apply_stimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b1);
    exp_vec = '0;
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_seq(2);

    // Sixteen R-type instructions wrap the 4-bit counter; run drops on the last.
    for (int k = 0; k < 16; k++) begin
      run_instr(K_R, 0, 0, 1'b0, k != 15, n, f);
      if (k == 0) check_val("len_r", n, 6);
    end
    check_val("wrap_retired", int'(retired), 0);
    check_val("wrap_idle_state", int'(state), 0);

    idle_seq(1);
    run_instr(K_I, 0, 0, 1'b0, 1'b1, n, f);       check_val("len_i", n, 6);
    run_instr(K_LOAD, 0, 0, 1'b0, 1'b1, n, f);    check_val("len_load", n, 7);
    run_instr(K_LOAD, 0, 3, 1'b0, 1'b1, n, f);    check_val("len_load_slow", n, 10);
    run_instr(K_STORE, 0, 3, 1'b0, 1'b1, n, f);   check_val("len_store_slow", n, 7);
    run_instr(K_STORE, 0, 0, 1'b0, 1'b1, n, f);   check_val("len_store", n, 4);
    run_instr(K_BRANCH, 0, 0, 1'b1, 1'b1, n, f);  check_val("len_branch", n, 3);
    run_instr(K_BRANCH, 0, 0, 1'b0, 1'b1, n, f);
    run_instr(K_JAL, 0, 0, 1'b0, 1'b1, n, f);     check_val("len_jal", n, 6);

    run_instr(K_R, TIMEOUT, 0, 1'b0, 1'b1, n, f);
    check_val("timeout_len", n, 15);
    check_val("timeout_state", int'(state), 6);
    check_val("timeout_fault", int'(fault), 1);
    fault_seq(2);
    idle_seq(0);
    run_instr(K_R, TIMEOUT - 1, 0, 1'b0, 1'b1, n, f);
    check_val("late_ready_len", n, 20);
    run_instr(K_ILL, 0, 0, 1'b0, 1'b1, n, f);
    check_val("illegal_state", int'(state), 6);
    fault_seq(0);
    idle_seq(0);

    in_fetch = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (!in_fetch) idle_seq($urandom_range(0, 2));
      kind = ($urandom_range(0, 99) < 8) ? K_ILL : $urandom_range(0, 5);
      re = ($urandom_range(0, 3) != 0);
      run_instr(kind, pick_delay(), pick_delay(), rb(), re, n, f);
      if (f) begin
        fault_seq($urandom_range(0, 3));
        in_fetch = 1'b0;
      end else begin
        in_fetch = re;
      end
    end

    // Asynchronous reset in the middle of an EXECUTE cycle.
    if (!in_fetch) idle_seq(0);
    emit(4'd1, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1);
    emit(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1'b1, 1'b0, legal_opc[K_R], 1'b0, 1'b1);
    check_val("pre_reset_state", int'(state), 3);
    exp_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val("async_reset_outputs", int'(act_vec), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_retired = '0;
    emit(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1);
    run_instr(K_R, 0, 0, 1'b0, 1'b0, n, f);
    check_val("post_reset_retired", int'(retired), 1);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
